// File: rtl/uart_seq_matcher_if.sv
// Bus between the UART sequence matcher and its consumer: pattern/mask in, byte/match events out.
// Optional UART_MATCH_COUNT_EN adds match_count and count_clr.
interface uart_seq_matcher_if #(
    parameter int unsigned PAT_BYTES = 4
);
    logic [8*PAT_BYTES-1:0] pattern;
    logic [8*PAT_BYTES-1:0] mask;
    logic [7:0]             byte_data;
    logic                   byte_valid;
    logic                   frame_err;
    logic                   match;
`ifdef UART_MATCH_COUNT_EN
    logic [15:0]            match_count;
    logic                   count_clr;
`endif

    modport master (
        input  pattern, mask,
`ifdef UART_MATCH_COUNT_EN
        input  count_clr,
        output match_count,
`endif
        output byte_data, byte_valid, frame_err, match
    );

    modport slave (
        output pattern, mask,
`ifdef UART_MATCH_COUNT_EN
        output count_clr,
        input  match_count,
`endif
        input  byte_data, byte_valid, frame_err, match
    );
endinterface

// File: rtl/uart_seq_matcher.sv
// 8N1 UART receiver with a PAT_BYTES-deep byte history compared against a masked pattern.
// Optional UART_MATCH_COUNT_EN adds a saturating match counter with synchronous clear.
module uart_seq_matcher #(
    parameter int unsigned CLK_DIV   = 217,
    parameter int unsigned PAT_BYTES = 4
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 rx_in,
    uart_seq_matcher_if.master   bus
);
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam int unsigned HIST_W = 8 * PAT_BYTES;
    localparam int unsigned FILL_W = $clog2(PAT_BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic [HIST_W-1:0]   history;
    logic [FILL_W-1:0]   fill;
    logic                rx_meta;
    logic                rx_s;
    logic                match_hit;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        match_hit = (((history ^ bus.pattern) & bus.mask) == '0)
                    && (fill == FILL_W'(PAT_BYTES));
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            history        <= '0;
            fill           <= '0;
            bus.byte_data  <= '0;
            bus.byte_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.match      <= 1'b0;
        end else begin
            bus.byte_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            // history is already updated while byte_valid is high, so match lands one cycle later
            bus.match      <= bus.byte_valid && match_hit;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_W'(CLK_DIV / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            bus.byte_data  <= shreg;
                            bus.byte_valid <= 1'b1;
                            history        <= (history << 8) | HIST_W'(shreg);
                            if (fill != FILL_W'(PAT_BYTES)) fill <= fill + 1'b1;
                        end else begin
                            bus.frame_err <= 1'b1;
                            history       <= '0;
                            fill          <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_MATCH_COUNT_EN
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bus.match_count <= '0;
        end else if (bus.count_clr) begin
            bus.match_count <= '0;
        end else if (bus.match && (bus.match_count != 16'hFFFF)) begin
            bus.match_count <= bus.match_count + 16'd1;
        end
    end
`endif
endmodule
